// File: rtl/gpio_bus_master.sv
// gpio_bus_master: polls the button register and writes display/PWM/animation updates on presses.
// Optional GPIO_MASTER_DEBOUNCE_EN: a button sample counts only when two consecutive polls agree.
module gpio_bus_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_DIV  = 1000,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr_err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        err,
    output logic [3:0]  disp_shadow,
    output logic [1:0]  anim_shadow
);
    typedef enum logic [2:0] {IDLE, RD_BTN, GAP, WR_DISP, WR_PWM, WR_ANIM} state_t;

    localparam logic [15:0] POLL_LAST = 16'(POLL_DIV - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] poll_cnt;
    logic [7:0]  wait_cnt;
    logic [1:0]  btn_prev, btn_cur, rise;
    logic        btn_ok, accept, timeout;
    logic        pend_disp, pend_pwm, pend_anim;
    logic [3:0]  disp_inc;
    logic [1:0]  anim_inc;
    logic        rdata_unused;

    assign btn_cur      = mem_rdata[1:0];
    assign rdata_unused = ^mem_rdata[31:2];
    assign rise         = btn_ok ? (btn_cur & ~btn_prev) : 2'b00;
    assign accept       = mem_valid & mem_ready;
    assign busy         = state != IDLE;
    assign disp_inc     = disp_shadow + 4'd1;
    assign anim_inc     = anim_shadow + 2'd1;

`ifdef GPIO_MASTER_DEBOUNCE_EN
    logic [1:0] btn_last;
    assign btn_ok = btn_cur == btn_last;
    // remember the previous completed poll so a sample is only trusted once repeated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_last <= 2'b00;
        else     btn_last <= (state == RD_BTN && accept) ? btn_cur : btn_last;
    end
`else
    assign btn_ok = 1'b1;
`endif

    // bus outputs decode straight from state so reset kills mem_valid immediately
    always_comb begin
        state_nx  = state;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        timeout   = 1'b0;
        case (state)
            IDLE:    state_nx = (en && poll_cnt == POLL_LAST) ? RD_BTN : IDLE;
            GAP:     state_nx = pend_disp ? WR_DISP : pend_pwm ? WR_PWM : pend_anim ? WR_ANIM : IDLE;
            RD_BTN:  begin
                mem_valid = 1'b1;
                mem_addr  = BASE_ADDR + 32'hC;
            end
            WR_DISP: begin
                mem_valid = 1'b1;
                mem_addr  = BASE_ADDR + 32'h4;
                mem_wdata = {28'd0, disp_inc};
                mem_wstrb = 4'hF;
            end
            WR_PWM:  begin
                mem_valid = 1'b1;
                mem_addr  = BASE_ADDR;
                mem_wdata = {28'd0, disp_shadow};
                mem_wstrb = 4'hF;
            end
            WR_ANIM: begin
                mem_valid = 1'b1;
                mem_addr  = BASE_ADDR + 32'h8;
                mem_wdata = {30'd0, anim_inc};
                mem_wstrb = 4'hF;
            end
            default: state_nx = IDLE;
        endcase
        timeout = mem_valid & ~mem_ready & (wait_cnt == WAIT_LAST);
        if (mem_valid) state_nx = timeout ? IDLE : mem_ready ? GAP : state;
    end

    // state, poll divider, handshake wait counter and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            poll_cnt <= 16'd0;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            poll_cnt <= (state == IDLE && en) ? ((poll_cnt == POLL_LAST) ? 16'd0 : poll_cnt + 16'd1) : poll_cnt;
            wait_cnt <= (mem_valid && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            err      <= timeout | (err & ~clr_err);
        end
    end

    // button edge capture, write queue and shadows; only accepted transfers change them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev    <= 2'b00;
            pend_disp   <= 1'b0;
            pend_pwm    <= 1'b0;
            pend_anim   <= 1'b0;
            disp_shadow <= 4'd0;
            anim_shadow <= 2'd0;
        end else if (timeout) begin
            pend_disp <= 1'b0;
            pend_pwm  <= 1'b0;
            pend_anim <= 1'b0;
        end else if (accept) begin
            if (state == RD_BTN) begin
                pend_disp <= rise[0];
                pend_pwm  <= rise[0];
                pend_anim <= rise[1];
                btn_prev  <= btn_ok ? btn_cur : btn_prev;
            end
            if (state == WR_DISP) begin
                pend_disp   <= 1'b0;
                disp_shadow <= disp_inc;
            end
            if (state == WR_PWM) pend_pwm <= 1'b0;
            if (state == WR_ANIM) begin
                pend_anim   <= 1'b0;
                anim_shadow <= anim_inc;
            end
        end
    end
endmodule

// File: tb/tb_gpio_bus_master.sv
// tb_gpio_bus_master: directed checks of polling, write sequencing, wrap, timeout and reset.
module tb_gpio_bus_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        clr_err = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        err;
    logic [3:0]  disp_shadow;
    logic [1:0]  anim_shadow;
    logic [1:0]  btns = 2'b00;
    logic        ready_en = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;
    int n;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_strb[$];
    int          q_cyc[$];

    assign mem_rdata = {30'd0, btns};
    assign mem_ready = mem_valid & ready_en;

    gpio_bus_master #(.BASE_ADDR(32'h0), .POLL_DIV(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .err(err), .disp_shadow(disp_shadow), .anim_shadow(anim_shadow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // log every accepted transfer with the cycle it completed in
    always @(negedge clk) begin
        if (mem_valid && mem_ready) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wdata);
            q_strb.push_back(mem_wstrb);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark(input logic [1:0] b);
        @(posedge clk);
        #1;
        btns = b;
        base = q_addr.size();
    endtask

    task automatic run_until(input int cnt);
        for (int i = 0; i < 300 && q_addr.size() < base + cnt; i++) @(negedge clk);
        check("txn_wait", 32'(q_addr.size() >= base + cnt), 32'd1);
    endtask

    task automatic chk_txn(input string tag, input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (q_addr.size() > base + k) begin
            check({tag, "_addr"}, q_addr[base+k], a);
            check({tag, "_data"}, q_data[base+k], d);
            check({tag, "_strb"}, 32'(q_strb[base+k]), 32'(s));
        end else begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    function automatic logic [31:0] dcyc(input int a, input int b);
        return (q_cyc.size() > base + b) ? 32'(q_cyc[base+b] - q_cyc[base+a]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        @(negedge clk);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_shadows", {26'd0, anim_shadow, disp_shadow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = 0;

        run_until(3);
        for (int k = 0; k < 3; k++) chk_txn("idle_poll", k, 32'hC, 32'd0, 4'd0);
        check("poll_period0", dcyc(0, 1), 32'd6);
        check("poll_period1", dcyc(1, 2), 32'd6);

        mark(2'b01);
        run_until(5);
        chk_txn("b0_rd", 0, 32'hC, 32'd0, 4'd0);
        chk_txn("b0_disp", 1, 32'h4, 32'd1, 4'hF);
        chk_txn("b0_pwm", 2, 32'h0, 32'd1, 4'hF);
        chk_txn("b0_hold1", 3, 32'hC, 32'd0, 4'd0);
        chk_txn("b0_hold2", 4, 32'hC, 32'd0, 4'd0);
        check("b0_gap1", dcyc(0, 1), 32'd2);
        check("b0_gap2", dcyc(1, 2), 32'd2);
        check("b0_next_poll", dcyc(0, 3), 32'd10);
        check("b0_disp_shadow", 32'(disp_shadow), 32'd1);

        mark(2'b00);
        run_until(1);
        mark(2'b11);
        run_until(5);
        chk_txn("both_disp", 1, 32'h4, 32'd2, 4'hF);
        chk_txn("both_pwm", 2, 32'h0, 32'd2, 4'hF);
        chk_txn("both_anim", 3, 32'h8, 32'd1, 4'hF);
        chk_txn("both_next", 4, 32'hC, 32'd0, 4'd0);
        check("both_seq_len", dcyc(0, 4), 32'd12);
        check("both_anim_shadow", 32'(anim_shadow), 32'd1);

        mark(2'b00);
        run_until(1);
        mark(2'b10);
        run_until(3);
        chk_txn("b1_anim", 1, 32'h8, 32'd2, 4'hF);
        chk_txn("b1_next", 2, 32'hC, 32'd0, 4'd0);
        check("b1_anim_shadow", 32'(anim_shadow), 32'd2);
        check("b1_disp_kept", 32'(disp_shadow), 32'd2);

        for (int p = 0; p < 13; p++) begin
            mark(2'b00);
            run_until(1);
            mark(2'b01);
            run_until(3);
        end
        check("pre_wrap_disp", 32'(disp_shadow), 32'd15);
        mark(2'b00);
        run_until(1);
        mark(2'b01);
        run_until(3);
        chk_txn("wrap_disp", 1, 32'h4, 32'd0, 4'hF);
        chk_txn("wrap_pwm", 2, 32'h0, 32'd0, 4'hF);
        check("wrap_shadow", 32'(disp_shadow), 32'd0);

        @(posedge clk);
        #1;
        ready_en = 1'b0;
        for (int i = 0; i < 20 && !mem_valid; i++) @(negedge clk);
        check("to_addr", mem_addr, 32'hC);
        n = 0;
        while (mem_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_hold_cycles", 32'(n), 32'd15);
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        ready_en = 1'b1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("clr_err", 32'(err), 32'd0);
        mark(2'b01);
        run_until(1);
        chk_txn("after_to", 0, 32'hC, 32'd0, 4'd0);
        check("after_to_err", 32'(err), 32'd0);
        check("after_to_disp", 32'(disp_shadow), 32'd0);

        @(posedge clk);
        #1;
        ready_en = 1'b0;
        for (int i = 0; i < 20 && !mem_valid; i++) @(negedge clk);
        check("mid_valid", 32'(mem_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(mem_valid), 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_shadows", {26'd0, anim_shadow, disp_shadow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_en = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
